// File: rtl/send_partition_if.sv
// send_partition_if: fill-stage tap, pass summary, next-pass control and pixel FIFO bus
interface send_partition_if #(parameter int BSB = 6);
  logic [7:0] in_px;
  logic in_px_valid;
  logic up_next;
  logic [7:0] pivot_samp;
  logic [BSB-1:0] k_samp;
  logic [BSB-1:0] lower_size;
  logic [BSB-1:0] equal_size;
  logic [BSB-1:0] larger_size;
  logic [7:0] min_lower;
  logic [7:0] max_lower;
  logic [7:0] min_larger;
  logic [7:0] max_larger;
  logic sending;
  logic control_sampled;
  logic [7:0] out_pivot;
  logic [BSB-1:0] out_buff_size;
  logic [BSB-1:0] out_k;
  logic [7:0] out_px;
  logic out_wr;
  logic out_full;
  logic [7:0] median;
  logic median_valid;
  modport master (
    output in_px, in_px_valid, up_next, pivot_samp, k_samp, lower_size, equal_size, larger_size,
           min_lower, max_lower, min_larger, max_larger, out_full,
    input  sending, control_sampled, out_pivot, out_buff_size, out_k, out_px, out_wr, median, median_valid
  );
  modport slave (
    input  in_px, in_px_valid, up_next, pivot_samp, k_samp, lower_size, equal_size, larger_size,
           min_lower, max_lower, min_larger, max_larger, out_full,
    output sending, control_sampled, out_pivot, out_buff_size, out_k, out_px, out_wr, median, median_valid
  );
endinterface

// File: rtl/send_partition.sv
// send_partition: quickselect writer; taps pixels into ping-pong banks, picks the rank-k partition
// and re-streams it or declares the median. SEND_CHECK_EN adds a sticky size_err stream-count check.
module send_partition #(
  parameter int BUFF_SIZE = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input logic clk,
  input logic rst,
`ifdef SEND_CHECK_EN
  output logic size_err,
`endif
  send_partition_if.slave bus
);
  localparam int AW = $clog2(BUFF_SIZE);
  localparam int BSB = BUFF_SIZE_BIT;
  localparam logic [BSB-1:0] FULL = BSB'(BUFF_SIZE);
  typedef enum logic [1:0] {IDLE, DECIDE, STREAM} state_t;
  state_t state;
  logic [7:0] mem [2][BUFF_SIZE];
  logic [BSB-1:0] wptr [2];
  logic tap;
  logic [BSB-1:0] rptr;
  logic [7:0] piv, mnl, mxl, mng, mxg;
  logic [BSB-1:0] k, ls, es, gs;
  logic sel_lower;
  logic [7:0] pend_px;
  logic pend_v;
  logic tap_ok;
  logic [BSB:0] le;
  logic go_lower, go_equal;
  logic [7:0] s_min, s_max;
  logic [8:0] s_sum;
  logic [BSB-1:0] len;
  logic qual, adv;
`ifdef SEND_CHECK_EN
  logic [BSB-1:0] wr_cnt;
`endif
  assign tap_ok = bus.in_px_valid && wptr[tap] < FULL;
  assign le = {1'b0, ls} + {1'b0, es};
  assign go_lower = {1'b0, k} < {1'b0, ls};
  assign go_equal = ~go_lower && {1'b0, k} < le;
  assign s_min = go_lower ? mnl : mng;
  assign s_max = go_lower ? mxl : mxg;
  assign s_sum = {1'b0, s_min} + {1'b0, s_max};
  assign len = wptr[~tap];
  // a pixel belongs to the chosen partition if it lies strictly on that side of the old pivot
  assign qual = pend_v && (sel_lower ? pend_px < piv : pend_px > piv);
  assign adv = ~(qual && bus.out_full);
  assign bus.out_wr = qual && ~bus.out_full;
  assign bus.out_px = pend_px;
  always_ff @(posedge clk)
    if (tap_ok) mem[tap][wptr[tap][AW-1:0]] <= bus.in_px;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tap <= 1'b0;
      wptr[0] <= '0;
      wptr[1] <= '0;
      rptr <= '0;
      piv <= '0;
      k <= '0;
      ls <= '0;
      es <= '0;
      gs <= '0;
      mnl <= '0;
      mxl <= '0;
      mng <= '0;
      mxg <= '0;
      sel_lower <= 1'b0;
      pend_px <= '0;
      pend_v <= 1'b0;
      bus.sending <= 1'b0;
      bus.control_sampled <= 1'b0;
      bus.out_pivot <= '0;
      bus.out_buff_size <= '0;
      bus.out_k <= '0;
      bus.median <= '0;
      bus.median_valid <= 1'b0;
`ifdef SEND_CHECK_EN
      wr_cnt <= '0;
      size_err <= 1'b0;
`endif
    end else begin
      bus.control_sampled <= 1'b0;
      bus.median_valid <= 1'b0;
      if (tap_ok) wptr[tap] <= wptr[tap] + 1'b1;
      case (state)
        IDLE: if (bus.up_next) begin
          state <= DECIDE;
          bus.sending <= 1'b1;
          tap <= ~tap;
          wptr[~tap] <= '0;
          piv <= bus.pivot_samp;
          k <= bus.k_samp;
          ls <= bus.lower_size;
          es <= bus.equal_size;
          gs <= bus.larger_size;
          mnl <= bus.min_lower;
          mxl <= bus.max_lower;
          mng <= bus.min_larger;
          mxg <= bus.max_larger;
        end
        DECIDE: begin
          sel_lower <= go_lower;
          if (go_equal || s_min == s_max) begin
            state <= IDLE;
            bus.sending <= 1'b0;
            bus.median <= go_equal ? piv : s_min;
            bus.median_valid <= 1'b1;
          end else begin
            state <= STREAM;
            bus.control_sampled <= 1'b1;
            bus.out_pivot <= s_sum[8:1];
            bus.out_buff_size <= go_lower ? ls : gs;
            bus.out_k <= go_lower ? k : k - ls - es;
            rptr <= '0;
`ifdef SEND_CHECK_EN
            wr_cnt <= '0;
`endif
          end
        end
        STREAM: begin
`ifdef SEND_CHECK_EN
          wr_cnt <= wr_cnt + BSB'(bus.out_wr);
          if (adv && rptr >= len && wr_cnt + BSB'(bus.out_wr) != bus.out_buff_size) size_err <= 1'b1;
`endif
          if (adv) begin
            if (rptr < len) begin
              pend_px <= mem[~tap][rptr[AW-1:0]];
              pend_v <= 1'b1;
              rptr <= rptr + 1'b1;
            end else begin
              pend_v <= 1'b0;
              state <= IDLE;
              bus.sending <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
